// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor
//   Memory-side partner of the cache data array. It turns one LINE_W-bit line
//   transfer into BEATS sequential BEAT_W-bit memory beats, least-significant
//   beat first.
//   - Fill (read): the incoming beats are gathered into c_line_o.
//   - Writeback (write): a latched copy of c_line_i is serialized onto m_wdata_o.
//
// Ports
//   clk        : clock; all state updates happen on its rising edge
//   rst        : synchronous reset, active-low
//   c_addr_i   : cache request byte address
//   c_read_i   : fill request (level, held until c_resp_o)
//   c_write_i  : writeback request (level, held until c_resp_o); wins over read
//   c_line_i   : line to write back
//   c_line_o   : assembled fill line; holds its value until the next fill
//   c_resp_o   : one-cycle completion pulse
//   m_addr_o   : line-aligned memory address
//   m_read_o   : registered burst read request
//   m_write_o  : registered burst write request
//   m_wdata_o  : current write beat
//   m_rdata_i  : read beat data
//   m_resp_i   : one pulse per beat (write beat accepted / read beat valid)
//   err_o      : timeout flag, valid with c_resp_o
//
// Build option
//   LBA_TIMEOUT_EN : when defined, an 8-bit watchdog aborts a burst after
//                    TIMEOUT_CYCLES consecutive cycles without m_resp_i and
//                    raises err_o with c_resp_o. When undefined, err_o is 0
//                    and a burst waits indefinitely.
module line_burst_adaptor #(
  parameter int unsigned LINE_W         = 256,
  parameter int unsigned BEAT_W         = 64,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] c_addr_i,
  input  logic              c_read_i,
  input  logic              c_write_i,
  input  logic [LINE_W-1:0] c_line_i,
  output logic [LINE_W-1:0] c_line_o,
  output logic              c_resp_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic              m_read_o,
  output logic              m_write_o,
  output logic [BEAT_W-1:0] m_wdata_o,
  input  logic [BEAT_W-1:0] m_rdata_i,
  input  logic              m_resp_i,
  output logic              err_o
);

  localparam int unsigned BEATS = LINE_W / BEAT_W;
  localparam int unsigned KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFF   = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [KW-1:0]     r_k;
  logic [LINE_W-1:0] r_line;
  logic [LINE_W-1:0] r_buf;
  logic [ADDR_W-1:0] r_addr;
  logic              r_m_read;
  logic              r_m_write;
  logic              w_last;
  logic              w_busy;
  logic              w_to;
  logic [31:0]       w_off;
  logic              w_unused_addr;

  assign w_busy        = (r_state == RD) || (r_state == WR);
  assign w_last        = (r_k == KW'(BEATS - 1));
  assign w_off         = 32'(r_k) * BEAT_W;
  assign w_unused_addr = &{1'b0, c_addr_i[OFF-1:0]};

`ifdef LBA_TIMEOUT_EN
  logic [7:0] r_wd;
  logic       r_err;

  // Fires on the cycle whose edge would make the idle count reach the limit,
  // so c_resp_o appears exactly TIMEOUT_CYCLES cycles after the last beat.
  assign w_to  = w_busy && !m_resp_i && (r_wd == 8'(TIMEOUT_CYCLES - 1));
  assign err_o = r_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_busy && !m_resp_i) r_wd <= r_wd + 8'd1;
      else                     r_wd <= '0;
      // Only high while in DONE, since w_to can only fire in RD/WR.
      r_err <= w_to;
    end
  end
`else
  assign w_to  = 1'b0;
  assign err_o = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    c_resp_o   = 1'b0;
    case (r_state)
      IDLE: begin
        if (c_write_i)     w_state_nx = WR;
        else if (c_read_i) w_state_nx = RD;
      end
      RD, WR: begin
        if ((m_resp_i && w_last) || w_to) w_state_nx = DONE;
      end
      DONE: begin
        c_resp_o   = 1'b1;
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_k       <= '0;
      r_line    <= '0;
      r_buf     <= '0;
      r_addr    <= '0;
      r_m_read  <= 1'b0;
      r_m_write <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      // Registered from next state: rise on entry, fall on exit, steady between.
      r_m_read  <= (w_state_nx == RD);
      r_m_write <= (w_state_nx == WR);
      case (r_state)
        IDLE: begin
          if (c_write_i || c_read_i) begin
            r_addr <= {c_addr_i[ADDR_W-1:OFF], {OFF{1'b0}}};
            r_k    <= '0;
          end
          if (c_write_i) r_buf <= c_line_i;
        end
        RD: begin
          if (m_resp_i) begin
            r_line[w_off +: BEAT_W] <= m_rdata_i;
            if (!w_last) r_k <= r_k + 1'b1;
          end
        end
        WR: begin
          if (m_resp_i && !w_last) r_k <= r_k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign c_line_o  = r_line;
  assign m_addr_o  = r_addr;
  assign m_read_o  = r_m_read;
  assign m_write_o = r_m_write;
  assign m_wdata_o = (r_state == WR) ? r_buf[w_off +: BEAT_W] : '0;

endmodule

// File: tb/tb_line_burst_adaptor.sv
module tb_line_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  c_addr_i = '0;
  logic         c_read_i = 1'b0;
  logic         c_write_i = 1'b0;
  logic [255:0] c_line_i = '0;
  logic [255:0] c_line_o;
  logic         c_resp_o;
  logic [31:0]  m_addr_o;
  logic         m_read_o;
  logic         m_write_o;
  logic [63:0]  m_wdata_o;
  logic [63:0]  m_rdata_i = '0;
  logic         m_resp_i = 1'b0;
  logic         err_o;

  int n_checks = 0;
  int n_errors = 0;

  line_burst_adaptor #(
    .LINE_W(256), .BEAT_W(64), .ADDR_W(32), .TIMEOUT_CYCLES(255)
  ) dut (
    .clk(clk), .rst(rst),
    .c_addr_i(c_addr_i), .c_read_i(c_read_i), .c_write_i(c_write_i),
    .c_line_i(c_line_i), .c_line_o(c_line_o), .c_resp_o(c_resp_o),
    .m_addr_o(m_addr_o), .m_read_o(m_read_o), .m_write_o(m_write_o),
    .m_wdata_o(m_wdata_o), .m_rdata_i(m_rdata_i), .m_resp_i(m_resp_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [63:0]  rb[4];
  logic [63:0]  wb[4];
  logic [63:0]  rb2[4];
  logic [255:0] fill1;
  logic [255:0] fill2;
  int           n;
  int           seen;

  initial begin
    rb  = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
            64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    wb  = '{64'hAAAA_0000_AAAA_0000, 64'hBBBB_1111_BBBB_1111,
            64'hCCCC_2222_CCCC_2222, 64'hDDDD_3333_DDDD_3333};
    rb2 = '{64'h6666_6666_6666_6666, 64'h7777_7777_7777_7777,
            64'h8888_8888_8888_8888, 64'h9999_9999_9999_9999};
    fill1 = {rb[3], rb[2], rb[1], rb[0]};
    fill2 = {rb2[3], rb2[2], rb2[1], rb2[0]};

    // Reset state
    tick; tick;
    check("rst_line",  c_line_o, '0);
    check("rst_resp",  256'(c_resp_o), 0);
    check("rst_mread", 256'(m_read_o), 0);
    check("rst_mwrite",256'(m_write_o), 0);
    check("rst_addr",  256'(m_addr_o), 0);
    check("rst_wdata", 256'(m_wdata_o), 0);
    check("rst_err",   256'(err_o), 0);
    rst = 1'b1;
    tick;

    // Zero-wait fill at 0x1234: accept cycle, 4 RD cycles, c_resp_o in the 6th cycle
    c_addr_i = 32'h0000_1234; c_read_i = 1'b1;
    tick;
    check("fill_mread_rise", 256'(m_read_o), 1);
    check("fill_addr", 256'(m_addr_o), 256'h1220);
    for (int i = 0; i < 4; i++) begin
      m_rdata_i = rb[i]; m_resp_i = 1'b1;
      tick;
      if (i < 3) begin
        check("fill_mread_hold", 256'(m_read_o), 1);
        check("fill_resp_early", 256'(c_resp_o), 0);
      end
    end
    check("fill_resp", 256'(c_resp_o), 1);
    check("fill_mread_fall", 256'(m_read_o), 0);
    check("fill_line", c_line_o, fill1);
    check("fill_err", 256'(err_o), 0);
    c_read_i = 1'b0; m_resp_i = 1'b0;
    tick;
    check("fill_resp_once", 256'(c_resp_o), 0);
    // Stray beat while idle must be ignored
    m_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF; m_resp_i = 1'b1;
    tick;
    check("idle_stray_line", c_line_o, fill1);
    check("idle_stray_mread", 256'(m_read_o), 0);
    m_resp_i = 1'b0;
    tick;

    // Writeback with 2 wait cycles per beat; c_line_i changes mid-burst
    c_line_i = {wb[3], wb[2], wb[1], wb[0]};
    c_addr_i = 32'h0000_ABCD; c_write_i = 1'b1;
    tick;
    c_line_i = '1;
    check("wb_mwrite_rise", 256'(m_write_o), 1);
    check("wb_addr", 256'(m_addr_o), 256'hABC0);
    for (int j = 0; j < 4; j++) begin
      for (int w = 0; w < 2; w++) begin
        check("wb_wdata", 256'(m_wdata_o), 256'(wb[j]));
        check("wb_mwrite_hold", 256'(m_write_o), 1);
        check("wb_resp_early", 256'(c_resp_o), 0);
        m_resp_i = 1'b0;
        tick;
      end
      check("wb_wdata_acc", 256'(m_wdata_o), 256'(wb[j]));
      m_resp_i = 1'b1;
      tick;
    end
    check("wb_resp", 256'(c_resp_o), 1);
    check("wb_mwrite_fall", 256'(m_write_o), 0);
    check("wb_line_held", c_line_o, fill1);
    c_write_i = 1'b0; m_resp_i = 1'b0;
    tick;
    check("wb_resp_once", 256'(c_resp_o), 0);

    // Simultaneous read+write: write first, one IDLE cycle, then the read
    c_addr_i = 32'h0000_2010; c_line_i = '0;
    c_read_i = 1'b1; c_write_i = 1'b1;
    tick;
    check("both_write_first", 256'(m_write_o), 1);
    check("both_no_read", 256'(m_read_o), 0);
    m_resp_i = 1'b1;
    repeat (4) tick;
    check("both_wr_resp", 256'(c_resp_o), 1);
    c_write_i = 1'b0; m_resp_i = 1'b0;
    tick;
    check("both_idle_mread", 256'(m_read_o), 0);
    check("both_idle_resp", 256'(c_resp_o), 0);
    tick;
    check("both_rd_start", 256'(m_read_o), 1);
    check("both_rd_addr", 256'(m_addr_o), 256'h2000);
    check("both_line_held", c_line_o, fill1);
    for (int i = 0; i < 4; i++) begin
      m_rdata_i = rb2[i]; m_resp_i = 1'b1;
      tick;
    end
    check("both_rd_resp", 256'(c_resp_o), 1);
    check("both_rd_line", c_line_o, fill2);
    c_read_i = 1'b0; m_resp_i = 1'b0;
    tick;

    // Reset after 2 read beats abandons the burst
    c_addr_i = 32'h0000_0300; c_read_i = 1'b1;
    tick;
    m_resp_i = 1'b1; m_rdata_i = 64'hABAB_ABAB_ABAB_ABAB;
    tick;
    m_rdata_i = 64'hCDCD_CDCD_CDCD_CDCD;
    tick;
    rst = 1'b0;
    tick;
    check("mrst_mread", 256'(m_read_o), 0);
    check("mrst_line", c_line_o, '0);
    check("mrst_resp", 256'(c_resp_o), 0);
    rst = 1'b1; c_read_i = 1'b0;
    m_rdata_i = 64'hEEEE_EEEE_EEEE_EEEE;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("mrst_stray_line", c_line_o, '0);
      check("mrst_stray_req", 256'({m_read_o, m_write_o, c_resp_o}), 0);
    end
    m_resp_i = 1'b0;
    tick;

    // Withheld beats after beat 0
    c_addr_i = 32'h0000_0400; c_read_i = 1'b1;
    tick;
    m_rdata_i = 64'h0123_4567_89AB_CDEF; m_resp_i = 1'b1;
    tick;
    m_resp_i = 1'b0; m_rdata_i = 64'h5A5A_5A5A_5A5A_5A5A;
`ifdef LBA_TIMEOUT_EN
    n = 0; seen = 0;
    while (n < 300 && seen == 0) begin
      tick;
      n++;
      if (c_resp_o) seen = 1;
    end
    check("to_cycles", 256'(n), 255);
    check("to_err", 256'(err_o), 1);
    check("to_line", c_line_o, {192'h0, 64'h0123_4567_89AB_CDEF});
    c_read_i = 1'b0;
    tick;
    check("to_err_clear", 256'(err_o), 0);
    check("to_resp_once", 256'(c_resp_o), 0);
`else
    seen = 0;
    repeat (1000) begin
      tick;
      if (c_resp_o) seen++;
    end
    check("nto_no_resp", 256'(seen), 0);
    check("nto_still_rd", 256'(m_read_o), 1);
    check("nto_err", 256'(err_o), 0);
    check("nto_line", c_line_o, {192'h0, 64'h0123_4567_89AB_CDEF});
    rst = 1'b0; c_read_i = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    check("nto_recover", 256'(m_read_o), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
